// File: rtl/mips_io_port_responder.sv
// Memory-mapped I/O responder for the MIPS MEM stage: PortOut, synchronized PortIn,
// sticky status (W1C) and a free-running timer inside a 16-byte window.
module mips_io_port_responder #(
   parameter int               NBits   = 32,
   parameter logic [NBits-1:0] IO_BASE = 32'h1001_0100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWrite,
   input  logic             MemRead,
   input  logic [NBits-1:0] Address,
   input  logic [NBits-1:0] WriteData,
   input  logic [7:0]       PortIn,
   output logic [NBits-1:0] ReadData,
   output logic             Hit,
   output logic [NBits-1:0] PortOut,
   output logic             InChanged
);

   localparam logic [1:0] SEL_PORT_OUT = 2'd0;
   localparam logic [1:0] SEL_PORT_IN  = 2'd1;
   localparam logic [1:0] SEL_STATUS   = 2'd2;
   localparam logic [1:0] SEL_TIMER    = 2'd3;

   logic [NBits-1:0] r_port_out;
   logic [NBits-1:0] r_timer;
   logic [1:0]       r_status;
   logic [7:0]       r_sync1, r_sync2, r_sync3;

   logic             w_win;
   logic [1:0]       w_sel;
   logic             w_wr;
   logic             w_wr_status;
   logic             w_wr_timer;
   logic             w_in_evt;
   logic             w_tmr_wrap;
   logic [1:0]       w_status_clr;
   logic [1:0]       w_status_next;
   logic [NBits-1:0] w_timer_next;
   logic             w_unused;

   // Byte lane bits are deliberately ignored: any alignment maps to the word register.
   assign w_unused = ^Address[1:0];

   assign w_win       = (Address[NBits-1:4] == IO_BASE[NBits-1:4]);
   assign w_sel       = Address[3:2];
   assign w_wr        = w_win & MemWrite;
   assign w_wr_status = w_wr & (w_sel == SEL_STATUS);
   assign w_wr_timer  = w_wr & (w_sel == SEL_TIMER);
   assign Hit         = w_win & (MemRead | MemWrite);

   assign w_in_evt = (r_sync2 != r_sync3);

   // Only the increment path can wrap; a store of all-ones must not flag it.
   assign w_tmr_wrap   = ~w_wr_timer & (&r_timer);
   assign w_timer_next = w_wr_timer ? WriteData : r_timer + 1'b1;

   assign w_status_clr  = w_wr_status ? WriteData[1:0] : 2'b00;
   assign w_status_next = (r_status & ~w_status_clr) | {w_tmr_wrap, w_in_evt};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_port_out <= '0;
         r_timer    <= '0;
         r_status   <= '0;
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_sync3    <= '0;
      end else begin
         r_sync1  <= PortIn;
         r_sync2  <= r_sync1;
         r_sync3  <= r_sync2;
         r_timer  <= w_timer_next;
         r_status <= w_status_next;
         if (w_wr && (w_sel == SEL_PORT_OUT)) begin
            r_port_out <= WriteData;
         end
      end
   end

   always_comb begin
      ReadData = '0;
      if (w_win && MemRead) begin
         unique case (w_sel)
            SEL_PORT_OUT: ReadData = r_port_out;
            SEL_PORT_IN:  ReadData = {{(NBits-8){1'b0}}, r_sync2};
            SEL_STATUS:   ReadData = {{(NBits-2){1'b0}}, r_status};
            SEL_TIMER:    ReadData = r_timer;
            default:      ReadData = '0;
         endcase
      end
   end

   assign PortOut   = r_port_out;
   assign InChanged = r_status[0];

endmodule

// File: tb/tb_mips_io_port_responder.sv
// Directed self-checking bench for mips_io_port_responder: register map, window decode,
// input synchronizer latency, W1C collisions, timer load/wrap and reset behaviour.
module tb_mips_io_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite, MemRead;
   logic [31:0] Address, WriteData;
   logic [7:0]  PortIn;
   logic [31:0] ReadData;
   logic        Hit;
   logic [31:0] PortOut;
   logic        InChanged;

   int n_total = 0;
   int n_bad   = 0;

   mips_io_port_responder #(.NBits(32), .IO_BASE(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .Address   (Address),
      .WriteData (WriteData),
      .PortIn    (PortIn),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .PortOut   (PortOut),
      .InChanged (InChanged)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      Address   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      MemRead   = 1'b0;
      tick();
      MemWrite  = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      Address  = addr;
      MemRead  = 1'b1;
      MemWrite = 1'b0;
      #1;
      check_val(tag, ReadData, exp);
      MemRead  = 1'b0;
   endtask

   initial begin
      reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
      Address = '0; WriteData = '0; PortIn = 8'h00;
      repeat (2) tick();
      check_val("rst_portout", PortOut, 32'h0);
      check_val("rst_inchg", {31'b0, InChanged}, 32'h0);
      check_val("rst_rdata_idle", ReadData, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Build up state, then reset mid-run
      wr(BASE, 32'h0000_00A5);
      check_val("portout_a5", PortOut, 32'h0000_00A5);
      PortIn = 8'h01;
      repeat (3) tick();
      check_val("pre_rst_inchg", {31'b0, InChanged}, 32'h1);
      reset = 1'b0;
      #1;
      check_val("async_rst_portout", PortOut, 32'h0);
      check_val("async_rst_inchg", {31'b0, InChanged}, 32'h0);
      rd_chk("rst_timer_low", BASE + 32'hC, 32'h0);
      PortIn = 8'h00;
      tick();
      check_val("rst_low_inchg", {31'b0, InChanged}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      rd_chk("post_rst_portout", BASE + 32'h0, 32'h0);
      rd_chk("post_rst_status", BASE + 32'h8, 32'h0);
      rd_chk("post_rst_timer", BASE + 32'hC, 32'h1);

      // PORT_OUT and window decode
      wr(BASE, 32'hDEAD_BEEF);
      check_val("portout_deadbeef", PortOut, 32'hDEAD_BEEF);
      rd_chk("rd_portout", BASE + 32'h0, 32'hDEAD_BEEF);
      rd_chk("rd_portout_unaligned", BASE + 32'h3, 32'hDEAD_BEEF);
      Address = BASE + 32'h10; WriteData = 32'h1234_5678; MemWrite = 1'b1; MemRead = 1'b1;
      #1;
      check_val("oow_hit", {31'b0, Hit}, 32'h0);
      check_val("oow_rdata", ReadData, 32'h0);
      tick();
      MemWrite = 1'b0; MemRead = 1'b0;
      check_val("oow_portout", PortOut, 32'hDEAD_BEEF);
      wr(BASE + 32'h4, 32'hFF);
      rd_chk("portin_store_ignored", BASE + 32'h4, 32'h0);

      // Input path latency
      PortIn = 8'h3C;
      tick();
      rd_chk("portin_1edge", BASE + 32'h4, 32'h0);
      tick();
      rd_chk("portin_2edge", BASE + 32'h4, 32'h3C);
      check_val("inchg_2edge", {31'b0, InChanged}, 32'h0);
      tick();
      check_val("inchg_3edge", {31'b0, InChanged}, 32'h1);
      rd_chk("status_inchg", BASE + 32'h8, 32'h1);
      wr(BASE + 32'h8, 32'h1);
      check_val("inchg_cleared", {31'b0, InChanged}, 32'h0);

      // Set wins over simultaneous clear
      PortIn = 8'h3D;
      repeat (2) tick();
      check_val("coll_pre", {31'b0, InChanged}, 32'h0);
      wr(BASE + 32'h8, 32'h1);
      check_val("coll_set_wins", {31'b0, InChanged}, 32'h1);
      wr(BASE + 32'h8, 32'h1);
      check_val("coll_cleared", {31'b0, InChanged}, 32'h0);

      // Timer load and wrap
      wr(BASE + 32'hC, 32'hFFFF_FFFE);
      rd_chk("tmr_load", BASE + 32'hC, 32'hFFFF_FFFE);
      tick();
      rd_chk("tmr_ones", BASE + 32'hC, 32'hFFFF_FFFF);
      rd_chk("tmr_status_prewrap", BASE + 32'h8, 32'h0);
      tick();
      rd_chk("tmr_wrap0", BASE + 32'hC, 32'h0);
      rd_chk("tmr_status_wrap", BASE + 32'h8, 32'h2);
      wr(BASE + 32'h8, 32'h2);
      rd_chk("tmr_status_clr", BASE + 32'h8, 32'h0);
      wr(BASE + 32'hC, 32'hFFFF_FFFF);
      rd_chk("tmr_load_ones_nowrap", BASE + 32'h8, 32'h0);
      tick();
      rd_chk("tmr_inc_wrap", BASE + 32'h8, 32'h2);

      // Simultaneous read and write
      wr(BASE, 32'h11);
      Address = BASE; WriteData = 32'h22; MemRead = 1'b1; MemWrite = 1'b1;
      #1;
      check_val("rw_rdata_old", ReadData, 32'h11);
      check_val("rw_hit", {31'b0, Hit}, 32'h1);
      tick();
      MemRead = 1'b0; MemWrite = 1'b0;
      check_val("rw_portout_new", PortOut, 32'h22);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
